fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//  Write-domain control stage of the dual-clock async FIFO; sits directly upstream of dpram.
//  Owns the write pointer and generates the Gray write address and write enable consumed by dpram.
//  Synchronises the read-domain Gray pointer into wclk and derives full, almost_full and fill level.
//  Exports the n-bit Gray write pointer for synchronisation into the read domain.
// PARAMETERS
//  n         5   pointer width in bits; FIFO depth = 2**(n-1), must match dpram n
//  AF_LEVEL  12  almost_full asserts when fill level >= AF_LEVEL (1..2**(n-1))
// PORTS
//  wclk      in   1    write clock; all state on posedge wclk
//  wrst      in   1    asynchronous, active-high reset
//  winc      in   1    write request from producer; data presented to dpram wdata same cycle
//  rptr_g    in   n    read-domain Gray pointer (asynchronous to wclk)
//  wen       out  1    write enable to dpram: winc & ~full (combinational)
//  waddr_g   out  n-1  Gray-coded write address to dpram: wbin[n-2:0] ^ (wbin[n-2:0]>>1), registered
//  wptr_g    out  n    Gray write pointer to read domain: wbin ^ (wbin>>1), registered
//  full      out  1    FIFO full, registered
//  almost_full out 1   fill level >= AF_LEVEL, registered
//  wcount    out  n    fill level seen from write side (0..2**(n-1)), registered
// BEHAVIOUR
//  - Reset (wrst=1, async): wbin, wptr_g, waddr_g, rq1, rq2, full, almost_full, wcount = 0.
//    wen therefore 0 only via winc; full deasserted, FIFO empty. Reset mid-write discards the write.
//  - Sync: rq1 <= rptr_g; rq2 <= rq1 (2-flop). Only rq2 used in logic; rbin = Gray->binary(rq2).
//  - Accept: write accepted on a wclk edge iff winc & ~full. dpram stores wdata at current
//    waddr_g on that same edge; wbin_next = wbin + 1 (mod 2**n, wraps 2**n-1 -> 0), else wbin.
//  - wptr_g/waddr_g update on the accepting edge (one Gray bit toggles per accepted write).
//  - full <= (gray(wbin_next) == {~rq2[n-1:n-2], rq2[n-3:0]}); asserts on the edge that
//    accepts the 2**(n-1)-th outstanding write, no bubble.
//  - wcount <= wbin_next - rbin (n-bit modular subtract); almost_full <= (that value >= AF_LEVEL).
//  - winc while full: ignored, wen=0, pointer/flags unchanged, no overwrite.
//  - Read-side advance: full/wcount/almost_full reflect a new rptr_g value on the 3rd wclk edge
//    after it is stable (2 sync + 1 flag register); flags are pessimistic (never falsely not-full).
//  - Simultaneous write accept and rq2 advance on same edge: both applied; full evaluated
//    with wbin_next and the new rq2 is seen next edge; wcount stays consistent (net 0).
//  - Pointer wrap: MSB of wbin toggles each pass; full/empty disambiguation relies on it.
//  - No FSM beyond pointer + flags; no combinational path rptr_g -> any output.
// TESTING (n=5, depth 16, AF_LEVEL=12, rptr_g held 0 unless stated)
//  1 Reset: wrst pulse mid-cycle -> all outputs 0 immediately, wen follows winc.
//  2 Fill: winc=1 for 16 edges -> waddr_g sequence 0,1,3,2,6,...; almost_full after 12th
//    write, full after 16th, wcount=16, wptr_g=5'b11000.
//  3 Overflow: winc=1 while full for 4 edges -> wen=0, wptr_g/waddr_g unchanged, dpram mem intact.
//  4 Drain: from full, set rptr_g=5'b00001 -> full=0 and wcount=15 on 3rd wclk edge.
//  5 Wrap: run 40 writes with rptr_g tracking 2 behind (gray) -> no full, wbin wraps 31->0,
//    waddr_g binary equivalent wraps 15->0, wcount never exceeds 16.
//  6 Simultaneous: at wcount=15 write and rptr_g advance together -> wcount stays 15, full never 1.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag stage of the dual-clock FIFO: owns the write pointer,
// drives the Gray write address/enable for dpram and derives full, almost_full and fill level.
module fifo_wptr_full #(
  parameter int n        = 5,
  parameter int AF_LEVEL = 12
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         winc,
  input  logic [n-1:0] rptr_g,
  output logic         wen,
  output logic [n-2:0] waddr_g,
  output logic [n-1:0] wptr_g,
  output logic         full,
  output logic         almost_full,
  output logic [n-1:0] wcount
);

  localparam logic [n-1:0] AF_THR = AF_LEVEL[n-1:0];

  logic [n-1:0] wbin;
  logic [n-1:0] rq1, rq2;
  logic [n-1:0] rbin;
  logic [n-1:0] wbin_next;
  logic [n-1:0] wgray_next;
  logic [n-2:0] wlow_next;
  logic [n-2:0] waddr_next;
  logic [n-1:0] wcount_next;
  logic         full_next;
  logic         af_next;

  assign wen = winc & ~full;

  always_comb begin
    rbin = '0;
    // each binary bit is the XOR of all Gray bits at and above it
    for (int i = 0; i < n; i++) begin
      rbin[i] = ^(rq2 >> i);
    end
    wbin_next   = wen ? wbin + n'(1) : wbin;
    wgray_next  = wbin_next ^ (wbin_next >> 1);
    wlow_next   = wbin_next[n-2:0];
    waddr_next  = wlow_next ^ (wlow_next >> 1);
    wcount_next = wbin_next - rbin;
    // full when the write pointer is exactly one lap ahead of the synchronised read pointer
    full_next   = (wgray_next == {~rq2[n-1:n-2], rq2[n-3:0]});
    af_next     = (wcount_next >= AF_THR);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rq1         <= '0;
      rq2         <= '0;
      wbin        <= '0;
      wptr_g      <= '0;
      waddr_g     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wcount      <= '0;
    end else begin
      rq1         <= rptr_g;
      rq2         <= rq1;
      wbin        <= wbin_next;
      wptr_g      <= wgray_next;
      waddr_g     <= waddr_next;
      full        <= full_next;
      almost_full <= af_next;
      wcount      <= wcount_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: fixed fill/overflow vectors, hand-written drain, wrap and
// concurrent read/write sequences, then random traffic against an occupancy-count model.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] rptr_g;
  logic       wen;
  logic [3:0] waddr_g;
  logic [4:0] wptr_g;
  logic       full;
  logic       almost_full;
  logic [4:0] wcount;

  fifo_wptr_full #(.n(5), .AF_LEVEL(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr_g(rptr_g),
    .wen(wen), .waddr_g(waddr_g), .wptr_g(wptr_g),
    .full(full), .almost_full(almost_full), .wcount(wcount)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: absolute counts of accepted writes and of reads presented on rptr_g.
  // The write side only learns of a read two edges after it is presented.
  int wr = 0, rd = 0;
  int seen1 = 0, seen2 = 0;
  int lvl = 0;
  bit m_full = 0;

  typedef struct {
    logic       winc;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       af;
    logic [4:0] wcount;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input int rd_new, output logic wen_s);
    int vis;
    @(negedge wclk);
    winc   = w;
    rd     = rd_new;
    rptr_g = gray5(rd % 32);
    #1;
    wen_s = wen;
    chk("wen", int'(wen), int'(w && !m_full));
    @(posedge wclk);
    vis   = seen2;
    seen2 = seen1;
    seen1 = rd;
    if (w && !m_full) wr++;
    lvl    = wr - vis;
    m_full = (lvl == 16);
    #1;
    chk("wptr_g",      int'(wptr_g),      int'(gray5(wr % 32)));
    chk("waddr_g",     int'(waddr_g),     int'(gray4(wr % 16)));
    chk("full",        int'(full),        int'(m_full));
    chk("almost_full", int'(almost_full), int'(lvl >= 12));
    chk("wcount",      int'(wcount),      lvl);
  endtask

  task automatic mid_reset();
    @(posedge wclk);
    #3;
    wrst = 1'b1;
    winc = 1'b1;
    #1;
    chk("rst_wptr_g", int'(wptr_g), 0);
    chk("rst_waddr_g", int'(waddr_g), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_wcount", int'(wcount), 0);
    chk("rst_wen_hi", int'(wen), 1);
    winc = 1'b0;
    #1;
    chk("rst_wen_lo", int'(wen), 0);
    winc   = 1'b1;
    rd     = 0;
    rptr_g = '0;
    @(posedge wclk);
    #1;
    chk("rst_discard", int'(wptr_g), 0);
    @(negedge wclk);
    wrst   = 1'b0;
    winc   = 1'b0;
    wr     = 0;
    seen1  = 0;
    seen2  = 0;
    lvl    = 0;
    m_full = 0;
  endtask

  initial begin
    logic ws;
    int   rn;
    int   p;

    tbl[0]  = '{1'b1, 1'b1, 4'h1, 5'h01, 1'b0, 1'b0, 5'd1};
    tbl[1]  = '{1'b1, 1'b1, 4'h3, 5'h03, 1'b0, 1'b0, 5'd2};
    tbl[2]  = '{1'b1, 1'b1, 4'h2, 5'h02, 1'b0, 1'b0, 5'd3};
    tbl[3]  = '{1'b1, 1'b1, 4'h6, 5'h06, 1'b0, 1'b0, 5'd4};
    tbl[4]  = '{1'b1, 1'b1, 4'h7, 5'h07, 1'b0, 1'b0, 5'd5};
    tbl[5]  = '{1'b1, 1'b1, 4'h5, 5'h05, 1'b0, 1'b0, 5'd6};
    tbl[6]  = '{1'b1, 1'b1, 4'h4, 5'h04, 1'b0, 1'b0, 5'd7};
    tbl[7]  = '{1'b1, 1'b1, 4'hc, 5'h0c, 1'b0, 1'b0, 5'd8};
    tbl[8]  = '{1'b1, 1'b1, 4'hd, 5'h0d, 1'b0, 1'b0, 5'd9};
    tbl[9]  = '{1'b1, 1'b1, 4'hf, 5'h0f, 1'b0, 1'b0, 5'd10};
    tbl[10] = '{1'b1, 1'b1, 4'he, 5'h0e, 1'b0, 1'b0, 5'd11};
    tbl[11] = '{1'b1, 1'b1, 4'ha, 5'h0a, 1'b0, 1'b1, 5'd12};
    tbl[12] = '{1'b1, 1'b1, 4'hb, 5'h0b, 1'b0, 1'b1, 5'd13};
    tbl[13] = '{1'b1, 1'b1, 4'h9, 5'h09, 1'b0, 1'b1, 5'd14};
    tbl[14] = '{1'b1, 1'b1, 4'h8, 5'h08, 1'b0, 1'b1, 5'd15};
    tbl[15] = '{1'b1, 1'b1, 4'h0, 5'h18, 1'b1, 1'b1, 5'd16};
    for (int i = 16; i < 20; i++) tbl[i] = '{1'b1, 1'b0, 4'h0, 5'h18, 1'b1, 1'b1, 5'd16};

    wrst   = 1'b1;
    winc   = 1'b0;
    rptr_g = '0;
    #2;
    chk("init_wptr_g", int'(wptr_g), 0);
    chk("init_full", int'(full), 0);
    chk("init_wcount", int'(wcount), 0);
    chk("init_wen", int'(wen), 0);
    @(negedge wclk);
    wrst = 1'b0;

    // fill then overflow
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].winc, 0, ws);
      chk($sformatf("tbl%0d_wen", i), int'(ws), int'(tbl[i].wen));
      chk($sformatf("tbl%0d_waddr", i), int'(waddr_g), int'(tbl[i].waddr));
      chk($sformatf("tbl%0d_wptr", i), int'(wptr_g), int'(tbl[i].wptr));
      chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].full));
      chk($sformatf("tbl%0d_af", i), int'(almost_full), int'(tbl[i].af));
      chk($sformatf("tbl%0d_wcount", i), int'(wcount), int'(tbl[i].wcount));
    end

    // drain one entry: visible on the 3rd edge
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1, ws);
      chk($sformatf("drain_full_e%0d", i + 1), int'(full), (i < 2) ? 1 : 0);
    end
    chk("drain_wcount", int'(wcount), 15);

    // concurrent read/write at level 15: reads start two edges ahead of writes
    for (int i = 0; i < 8; i++) begin
      step(i >= 2, rd + 1, ws);
      chk($sformatf("sim_wcount%0d", i), int'(wcount), 15);
      chk($sformatf("sim_full%0d", i), int'(full), 0);
    end

    mid_reset();

    // wrap: 40 writes with reads trailing two behind
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (wr >= 2) ? wr - 2 : 0, ws);
      chk("wrap_nofull", int'(full), 0);
      chk("wrap_le16", int'(wcount <= 5'd16), 1);
    end
    chk("wrap_count", wr, 40);

    // random traffic, slow reader then fast reader
    for (int i = 0; i < 600; i++) begin
      p  = (i < 300) ? 30 : 85;
      rn = rd;
      if (rd < wr && $urandom_range(0, 99) < p) rn = rd + 1;
      step(logic'($urandom_range(0, 3) != 0), rn, ws);
    end

    mid_reset();
    step(1'b1, 0, ws);
    chk("post_rst_wptr", int'(wptr_g), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
